// File: rtl/booth_mul_sequencer.sv
// booth_mul_sequencer: valid/ready issue stage for booth_multiplier with result capture, watchdog and optional MAC
// Ports: in_* operand stream (valid/ready, sign, a, b, last); mul_* start/operands to and product/ready from
// the multiplier; out_* result stream (valid/ready, data, err); timeout_sticky latches any watchdog abort.
// Define BOOTH_SEQ_ACC_EN to build the accumulator: results are then emitted only on in_last beats.
module booth_mul_sequencer #(
  parameter int MUL_WIDTH      = 4,
  parameter int ACC_WIDTH      = 12,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   in_sign,
  input  logic [MUL_WIDTH-1:0]   in_a,
  input  logic [MUL_WIDTH-1:0]   in_b,
  input  logic                   in_last,
  output logic                   mul_start,
  output logic                   mul_sign,
  output logic [MUL_WIDTH-1:0]   mul_data_in1,
  output logic [MUL_WIDTH-1:0]   mul_data_in2,
  input  logic [2*MUL_WIDTH-1:0] mul_data_out,
  input  logic                   mul_ready,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ACC_WIDTH-1:0]   out_data,
  output logic                   out_err,
  output logic                   timeout_sticky
);
  localparam int PW = 2 * MUL_WIDTH;
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [ACC_WIDTH-1:0] HI_MASK = {ACC_WIDTH{1'b1}} << PW;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, OUT} state_e;
  state_e state_q, state_d;
  logic sign_q, sign_d;
  logic [MUL_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic rdy_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [ACC_WIDTH-1:0] data_q, data_d, prod_ext;
  logic err_q, err_d, sticky_q, sticky_d;
  logic done;
`ifdef BOOTH_SEQ_ACC_EN
  logic last_q, last_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
`else
  logic unused_last;
  assign unused_last = in_last;
`endif
  // only a low->high transition of the done level counts, so a level left high by a previous job is ignored
  assign done = mul_ready && !rdy_q;
  // sign-extend by OR-ing ones above the product when it is a negative signed result
  assign prod_ext = ACC_WIDTH'(mul_data_out) | ((sign_q && mul_data_out[PW-1]) ? HI_MASK : '0);
  assign in_ready = rst_n && state_q == IDLE;
  assign mul_start = state_q == ISSUE;
  assign out_valid = state_q == OUT;
  assign mul_sign = sign_q;
  assign mul_data_in1 = a_q;
  assign mul_data_in2 = b_q;
  assign out_data = data_q;
  assign out_err = err_q;
  assign timeout_sticky = sticky_q;
  always_comb begin
    state_d = state_q;
    sign_d = sign_q;
    a_d = a_q;
    b_d = b_q;
    cnt_d = cnt_q;
    data_d = data_q;
    err_d = err_q;
    sticky_d = sticky_q;
`ifdef BOOTH_SEQ_ACC_EN
    last_d = last_q;
    acc_d = acc_q;
`endif
    unique case (state_q)
      IDLE: if (in_valid) begin
        sign_d = in_sign;
        a_d = in_a;
        b_d = in_b;
`ifdef BOOTH_SEQ_ACC_EN
        last_d = in_last;
`endif
        state_d = ISSUE;
      end
      ISSUE: begin
        cnt_d = '0;
        state_d = WAIT;
      end
      WAIT: if (done) begin
`ifdef BOOTH_SEQ_ACC_EN
        if (last_q) begin
          data_d = acc_q + prod_ext;
          acc_d = '0;
          err_d = 1'b0;
          state_d = OUT;
        end else begin
          acc_d = acc_q + prod_ext;
          state_d = IDLE;
        end
`else
        data_d = prod_ext;
        err_d = 1'b0;
        state_d = OUT;
`endif
      end else if (cnt_q == CW'(TIMEOUT_CYCLES - 1)) begin
        data_d = '0;
        err_d = 1'b1;
        sticky_d = 1'b1;
`ifdef BOOTH_SEQ_ACC_EN
        acc_d = '0;
`endif
        state_d = OUT;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
      OUT: if (out_ready) begin
        err_d = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sign_q <= 1'b0;
      a_q <= '0;
      b_q <= '0;
      rdy_q <= 1'b0;
      cnt_q <= '0;
      data_q <= '0;
      err_q <= 1'b0;
      sticky_q <= 1'b0;
`ifdef BOOTH_SEQ_ACC_EN
      last_q <= 1'b0;
      acc_q <= '0;
`endif
    end else begin
      state_q <= state_d;
      sign_q <= sign_d;
      a_q <= a_d;
      b_q <= b_d;
      rdy_q <= mul_ready;
      cnt_q <= cnt_d;
      data_q <= data_d;
      err_q <= err_d;
      sticky_q <= sticky_d;
`ifdef BOOTH_SEQ_ACC_EN
      last_q <= last_d;
      acc_q <= acc_d;
`endif
    end
  end
endmodule

// File: tb/tb_booth_mul_sequencer.sv
// tb_booth_mul_sequencer: randomized and directed bench for booth_mul_sequencer with a behavioural multiplier stub
module tb_booth_mul_sequencer;
  localparam int MW = 4;
  localparam int AW = 12;
  localparam int TO = 64;
`ifdef BOOTH_SEQ_ACC_EN
  localparam bit ACC = 1'b1;
`else
  localparam bit ACC = 1'b0;
`endif
  logic clk, rst_n, in_valid, in_ready, in_sign, in_last;
  logic [MW-1:0] in_a, in_b, mul_data_in1, mul_data_in2;
  logic mul_start, mul_sign, mul_ready, out_valid, out_ready, out_err, timeout_sticky;
  logic [2*MW-1:0] mul_data_out;
  logic [AW-1:0] out_data;
  int tests, fails;
  booth_mul_sequencer #(.MUL_WIDTH(MW), .ACC_WIDTH(AW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_sign(in_sign),
    .in_a(in_a), .in_b(in_b), .in_last(in_last), .mul_start(mul_start), .mul_sign(mul_sign),
    .mul_data_in1(mul_data_in1), .mul_data_in2(mul_data_in2), .mul_data_out(mul_data_out),
    .mul_ready(mul_ready), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_err(out_err), .timeout_sticky(timeout_sticky)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @%0t: got %0h, want %0h", nm, $time, act, exp);
    end
  endtask
  function automatic int opv(bit s, logic [MW-1:0] v);
    return s ? int'($signed(v)) : int'(v);
  endfunction
  typedef struct packed { bit on; bit e; logic [AW-1:0] d; } lit_t;
  lit_t lits[$];
  lit_t cur_lit;
  bit m_busy, m_out, m_err, m_sticky, m_s, m_l, prev_rdy;
  logic [MW-1:0] m_a, m_b;
  logic [AW-1:0] m_data, m_p, acc;
  int cyc, t_hs;
  // reference model: events are timestamped in cycles; checks use the state reached at the previous cycle
  initial begin
    cyc = 0;
    t_hs = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst_n) begin
        m_busy = 0; m_out = 0; m_err = 0; m_sticky = 0; m_s = 0; m_l = 0;
        m_a = '0; m_b = '0; m_data = '0; acc = '0; prev_rdy = 0;
        lits.delete();
      end
      chk("in_ready", in_ready, rst_n && !m_busy && !m_out);
      chk("mul_start", mul_start, m_busy && cyc == t_hs + 1);
      chk("out_valid", out_valid, m_out);
      chk("out_err", out_err, m_err);
      chk("timeout_sticky", timeout_sticky, m_sticky);
      chk("mul_sign", mul_sign, m_s);
      chk("mul_data_in1", mul_data_in1, m_a);
      chk("mul_data_in2", mul_data_in2, m_b);
      if (m_out || !rst_n) chk("out_data", out_data, m_data);
      if (rst_n) begin
        if (m_out) begin
          if (out_ready) begin
            if (lits.size() > 0) begin
              lit_t l;
              l = lits.pop_front();
              if (l.on) begin
                chk("literal_data", out_data, l.d);
                chk("literal_err", out_err, l.e);
              end
            end
            m_out = 0;
            m_err = 0;
          end
        end else if (!m_busy) begin
          if (in_valid) begin
            m_busy = 1; t_hs = cyc; m_s = in_sign; m_a = in_a; m_b = in_b; m_l = in_last;
            m_p = AW'(opv(in_sign, in_a) * opv(in_sign, in_b));
            if (!ACC || in_last) lits.push_back(cur_lit);
          end
        end else if (cyc >= t_hs + 2) begin
          if (mul_ready && !prev_rdy) begin
            if (ACC && !m_l) begin
              acc = acc + m_p;
              m_busy = 0;
            end else begin
              m_data = acc + m_p; acc = '0; m_err = 0; m_out = 1; m_busy = 0;
            end
          end else if (cyc == t_hs + 1 + TO) begin
            m_data = '0; m_err = 1; m_sticky = 1; acc = '0; m_out = 1; m_busy = 0;
          end
        end
        prev_rdy = mul_ready;
      end
    end
  end
  // multiplier stub: mode 0 normal latency, 1 never completes, 2 keeps done high then drops and re-raises it
  int stub_mode, cd;
  bit st;
  logic [2*MW-1:0] sp, hold_p;
  initial begin
    stub_mode = 0;
    cd = 0;
    hold_p = '0;
    mul_ready = 1'b0;
    mul_data_out = '0;
    forever begin
      @(negedge clk);
      st = mul_start;
      sp = (2*MW)'(opv(mul_sign, mul_data_in1) * opv(mul_sign, mul_data_in2));
      @(posedge clk);
      #1;
      if (st) begin
        hold_p = sp;
        cd = stub_mode == 0 ? int'($urandom_range(1, 5)) : (stub_mode == 2 ? 6 : 0);
        if (stub_mode != 2) mul_ready = 1'b0;
      end else if (cd > 0) begin
        cd--;
        if (stub_mode == 2 && cd == 1) mul_ready = 1'b0;
        if (cd == 0) begin
          mul_ready = 1'b1;
          mul_data_out = hold_p;
        end
      end
    end
  end
  bit hold_ready, rnd_ready;
  initial begin
    hold_ready = 0;
    rnd_ready = 0;
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      out_ready = hold_ready ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end
  task automatic put(bit s, logic [MW-1:0] a, logic [MW-1:0] b, bit l, bit on, logic [AW-1:0] d, bit e);
    in_valid = 1'b1; in_sign = s; in_a = a; in_b = b; in_last = l;
    cur_lit = '{on: on, e: e, d: d};
  endtask
  task automatic take();
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("handshake_bound", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask
  task automatic wait_out();
    int n;
    n = 0;
    @(negedge clk);
    while (!out_valid && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("out_valid_bound", out_valid, 1);
  endtask
  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while ((m_busy || m_out) && n < 500) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("drain_bound", n < 500, 1);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #300000;
    $display("FAIL global_timeout @%0t", $time);
    $fatal(1);
  end
  initial begin
    tests = 0;
    fails = 0;
    rst_n = 1'b0;
    in_valid = 1'b0; in_sign = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0;
    cur_lit = '0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    put(0, 4'd6, 4'd3, 1, 1, 12'h012, 0); take();
    put(1, 4'hA, 4'd3, 1, 1, 12'hFEE, 0); take();
    put(1, 4'h9, 4'hE, 1, 1, 12'h00E, 0); take();
    put(0, 4'hF, 4'hF, 1, 1, 12'h0E1, 0); take();
    drain();
    hold_ready = 1;
    put(0, 4'd5, 4'd7, 1, 1, 12'h023, 0); take();
    wait_out();
    @(posedge clk);
    #1;
    put(0, 4'd2, 4'd2, 1, 1, 12'h004, 0);
    repeat (5) @(posedge clk);
    #1;
    hold_ready = 0;
    take();
    drain();
    stub_mode = 1;
    put(1, 4'd3, 4'd3, 1, 1, 12'h000, 1); take();
    wait_out();
    chk("sticky_after_timeout", timeout_sticky, 1);
    drain();
    stub_mode = 0;
    put(0, 4'd3, 4'd5, 1, 1, 12'h00F, 0); take();
    drain();
    stub_mode = 2;
    put(0, 4'd2, 4'd3, 1, 1, 12'h006, 0); take();
    drain();
    stub_mode = 0;
    rnd_ready = 1;
    repeat (40) begin
      put(1'($urandom_range(0, 1)), 4'($urandom), 4'($urandom), 1'($urandom_range(0, 1)), 0, '0, 0);
      take();
    end
    drain();
    rnd_ready = 0;
    put(1, 4'h7, 4'h6, 1, 0, '0, 0); take();
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    put(0, 4'd7, 4'd7, 1, 1, 12'h031, 0); take();
    drain();
`ifdef BOOTH_SEQ_ACC_EN
    put(1, 4'd3, 4'd2, 0, 0, '0, 0); take();
    put(1, 4'hF, 4'd5, 0, 0, '0, 0); take();
    put(1, 4'd4, 4'd4, 1, 1, 12'h011, 0); take();
    drain();
    put(1, 4'd3, 4'd3, 0, 0, '0, 0); take();
    drain();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    put(0, 4'd2, 4'd2, 1, 1, 12'h004, 0); take();
    drain();
`endif
    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/booth_mul_sequencer.md
# booth_mul_sequencer

Upstream issue stage for `booth_multiplier`. It accepts operand pairs from a valid/ready stream, holds them stable, and pulses the multiplier's `start`. When the multiplier's `ready` rises it captures the product and presents it downstream on a valid/ready result port. It also provides a watchdog timeout and an optional compile-time multiply-accumulate mode.

## Interface
- `MUL_WIDTH`, default 4: operand width; must match the multiplier's `MUL_WIDTH`.
- `ACC_WIDTH`, default 12: result/accumulator width; must be ≥ 2*MUL_WIDTH.
- `TIMEOUT_CYCLES`, default 64: maximum WAIT cycles before abort; ≥ 2.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand beat valid.
- `in_ready` out 1: sequencer can accept a beat.
- `in_sign` in 1: 1 means signed (two's complement) multiply.
- `in_a` in MUL_WIDTH: operand 1.
- `in_b` in MUL_WIDTH: operand 2.
- `in_last` in 1: closes an accumulation group; ignored unless accumulation is compiled in.
- `mul_start` out 1: one-cycle start pulse to the multiplier.
- `mul_sign` out 1: registered `in_sign`.
- `mul_data_in1` out MUL_WIDTH: registered `in_a`.
- `mul_data_in2` out MUL_WIDTH: registered `in_b`.
- `mul_data_out` in 2*MUL_WIDTH: product from the multiplier.
- `mul_ready` in 1: multiplier done flag (level).
- `out_valid` out 1: result valid.
- `out_ready` in 1: downstream accepts the result.
- `out_data` out ACC_WIDTH: extended product, or the accumulated sum.
- `out_err` out 1: the result was produced by a timeout abort.
- `timeout_sticky` out 1: a timeout has occurred since reset.

## Operation
- FSM states: IDLE, ISSUE, WAIT, OUT. Reset state is IDLE.
- **IDLE**
  - `in_ready`=1.
  - On `in_valid`, register sign/a/b/last, then go to ISSUE.
- **ISSUE**
  - `mul_start`=1 for exactly this cycle.
  - Clear the timeout counter, then go to WAIT.
- **WAIT**
  - Completion is a rising edge on `mul_ready`: `mul_ready`=1 while the registered `mul_ready_q`=0.
  - `mul_ready_q` updates every cycle.
  - A level that was already high on entry to WAIT does not count as completion.
  - On the edge, capture `mul_data_out`. Extend it to ACC_WIDTH: sign-extend if `mul_sign`=1, zero-extend otherwise.
- **Routing after capture**
  - Without accumulation: go to OUT.
  - With accumulation and `last`=0: add the product to `acc` and go to IDLE.
  - With accumulation and `last`=1: load `out_data` = `acc` + product, clear `acc`, go to OUT.
- **Timeout**
  - The counter increments in WAIT.
  - When it reaches TIMEOUT_CYCLES with no edge: `out_data`=0, `out_err`=1, `timeout_sticky`=1, clear `acc`, go to OUT.
- **OUT**
  - `out_valid`=1; `out_data` and `out_err` are held stable.
  - On `out_ready`, go to IDLE and clear `out_err`.
- **Stable outputs**
  - `mul_sign`, `mul_data_in1` and `mul_data_in2` change only on input capture in IDLE.
  - They are stable from ISSUE through WAIT.
- **Arithmetic**
  - Accumulator addition wraps modulo 2^ACC_WIDTH.
  - No saturation and no overflow flag.
- **Reset mid-operation**
  - Return to IDLE immediately and drop the pending result.
  - A multiplier still in flight is ignored: its late `ready` edge arrives outside WAIT and is discarded.
- **Reset values**
  - `in_ready`=0 while `rst_n`=0, and 1 after release.
  - All other outputs are 0: `mul_start`, `mul_sign`, `mul_data_in1/2`, `out_valid`, `out_data`, `out_err`, `timeout_sticky`.
  - `acc`=0 and `mul_ready_q`=0.

## Timing
- Input handshake at edge T → `mul_start`=1 during cycle T+1 → WAIT from T+2.
- `mul_ready` rising edge sampled at edge E → `out_valid`=1 from E+1 (non-accumulate, or a `last` beat).
- Zero-wait downstream: OUT lasts 1 cycle, and `in_ready` returns the cycle after `out_ready`.
- Throughput: one operand pair per (multiplier latency + 3 + output stall) cycles.
- `in_ready` is high only in IDLE, so `in_valid` held during a busy period is not consumed.
- `mul_start` is never asserted outside ISSUE.
- `timeout_sticky` clears only on reset.

## Configuration
- `BOOTH_SEQ_ACC_EN` defined:
  - The accumulator register and `in_last` handling are built.
  - A result is emitted only on a `last` beat, carrying the group sum.
- `BOOTH_SEQ_ACC_EN` undefined:
  - No accumulator; `in_last` is ignored.
  - Every beat emits its own extended product.
- Port list is identical in both builds.

## Test plan
- Unsigned 6×3, zero-wait downstream → `out_data`=0x012, `out_err`=0; `mul_start` is exactly 1 cycle, the cycle after the handshake.
- Signed operands, with distinct values checked for sign handling:
  - -6×3 → 0xFEE (-18).
  - -7×-2 → 0x00E.
  - Unsigned 15×15 → 0x0E1 (zero-extended, not sign-extended).
- Downstream backpressure: `out_ready`=0 for 5 cycles → `out_valid` and `out_data` stay stable; `in_ready`=0 throughout; next `in_valid` is accepted only after the handshake.
- Multiplier stub never raises `ready` → after 64 WAIT cycles: `out_valid`=1, `out_data`=0, `out_err`=1, `timeout_sticky`=1; next operation completes normally with `out_err`=0.
- Stub holds `mul_ready` high across ISSUE and WAIT without an edge → no false completion; the later low→high transition completes the operation.
- With `BOOTH_SEQ_ACC_EN`, signed beats (3×2, last=0), (-1×5, last=0), (4×4, last=1) → single output 0x011 (17). Assert `rst_n` mid-group, then send one last beat 2×2 → 0x004 (accumulator was cleared).
